conv_sequencer: RTL and testbench
=================================

# conv_sequencer

Conversion sequencer for the ADC acquisition chain. It drives the ADC convert/ready handshake, clears and enables the CIC stage once per accepted sample, and fires the FIR stage once per decimation frame. It sits between the register block (`conv_en`, `decimation_ratio`) and the datapath (`cic_clr`, `cic_en`, `fir_en`), and adds an ADC timeout with a sticky error flag.

## Interface
- `ADC_TIMEOUT`, default 64: maximum number of cycles spent in WAIT_ADC before an error is flagged. Legal range 2..255.
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst`  input  1  synchronous reset, active-high.
- `conv_en`  input  1  level; continuous conversion enable from the register block.
- `decimation_ratio`  input  2  frame length N = 2^(ratio+1): 0→2, 1→4, 2→8, 3→16.
- `adc_ready`  input  1  ADC conversion done; level, sampled only in WAIT_ADC.
- `adc_convert`  output  1  conversion request to the ADC.
- `cic_clr`  output  1  one-cycle CIC accumulator clear at frame start.
- `cic_en`  output  1  one-cycle CIC accumulate strobe per accepted sample.
- `fir_en`  output  1  one-cycle FIR strobe per completed frame.
- `busy`  output  1  high in every state except IDLE and ERR.
- `timeout_err`  output  1  sticky ADC timeout flag.

## Operation
- The FSM states are IDLE, CLEAR, START, WAIT_ADC, ACCUM, FIR and ERR.
- All outputs are Moore outputs decoded from registered state. There is no combinational input-to-output path.
- Output decode:
  - `cic_clr` = CLEAR.
  - `adc_convert` = START or WAIT_ADC.
  - `cic_en` = ACCUM.
  - `fir_en` = FIR.
- State transitions:
  - IDLE: `conv_en` = 1 → CLEAR.
  - CLEAR: latch N from `decimation_ratio`, clear the sample counter → START. Ratio changes mid-frame are ignored.
  - START: → WAIT_ADC. Clear the timeout counter.
  - WAIT_ADC: `adc_ready` → ACCUM. Otherwise increment the timeout counter; when it reaches `ADC_TIMEOUT`-1 without ready → ERR.
  - ACCUM: increment the sample counter. If the counter was N-1 → FIR, else → START.
  - FIR: `conv_en` = 1 → CLEAR, else → IDLE.
  - ERR: sets `timeout_err`. `conv_en` = 0 → IDLE; `timeout_err` stays set.
- Abort: `conv_en` = 0 observed in START or WAIT_ADC → IDLE. The partial frame is discarded and `fir_en` does not fire.
- `conv_en` = 0 during CLEAR or ACCUM is acted on at the next START.
- `timeout_err` clears only on `rst` or on the IDLE→CLEAR transition.
- The sample counter is 4 bits and the timeout counter is 8 bits. Both saturate rather than wrap.
- Simultaneous events:
  - `adc_ready` arriving in the same cycle the timeout expires: ready wins → ACCUM.
  - `adc_ready` outside WAIT_ADC is ignored.
- Reset (including mid-frame):
  - State = IDLE, both counters = 0.
  - All outputs 0, including `timeout_err`.
  - Any in-flight conversion is abandoned.

## Timing
- `conv_en` sampled high at edge 0 → `cic_clr` high in cycle 1 → `adc_convert` high from cycle 2.
- `adc_ready` sampled high at edge k:
  - `adc_convert` is low and `cic_en` is high in cycle k+1.
  - `adc_convert` is high again in cycle k+2, unless this was the last sample of the frame.
- Last sample of a frame: `fir_en` high in cycle k+2. `cic_clr` follows in cycle k+3 if `conv_en` is still high.
- Minimum frame length with ready returned immediately: 1 + 3N + 1 cycles.
  - 3N covers START, WAIT_ADC and ACCUM for each sample.
  - The first 1 is CLEAR and the last 1 is FIR.
- Timeout: ERR is entered ADC_TIMEOUT cycles after WAIT_ADC entry. `adc_convert` drops the same cycle.
- Each strobe (`cic_clr`, `cic_en`, `fir_en`) is exactly one cycle wide. No two strobes are ever high in the same cycle.

## Structure
- Shared package `conv_seq_pkg` contains:
  - the `conv_state_t` enum;
  - function `ratio_to_n(logic [1:0]) → logic [4:0]`;
  - localparams for the counter widths.
- The register block and the datapath testbench import this package for the ratio decode.
- No sub-module: one FSM plus two counters in a single module.

## Test plan
- Reset mid-WAIT_ADC: assert `rst` for 1 cycle → next cycle all outputs 0, `busy` = 0, and a new `conv_en` restarts at CLEAR.
- `decimation_ratio` = 1, `conv_en` held, ready returned 1 cycle after each convert → exactly 4 `cic_en` pulses per `fir_en`, one `cic_clr` per frame, frame period 14 cycles.
- Ratio changed from 0 to 3 mid-frame → the current frame completes with N = 2; the next frame uses N = 16.
- `ADC_TIMEOUT` = 8 and ready never asserted → ERR 8 cycles after WAIT_ADC entry, `timeout_err` = 1, `adc_convert` = 0.
  - `conv_en` low → IDLE with `timeout_err` still 1.
  - `conv_en` high again → `timeout_err` = 0.
- `conv_en` dropped while in WAIT_ADC with sample 2 of 4 pending → IDLE next cycle, no `fir_en`, `adc_convert` low.
- `adc_ready` in the same cycle the timeout expires → ACCUM with `cic_en` pulse and no error. `adc_ready` pulsed during IDLE → no response.

Source files
------------

// File: rtl/conv_seq_pkg.sv
// conv_seq_pkg: shared types and helpers for the ADC conversion sequencer.
//   conv_state_t   - sequencer FSM state encoding
//   ratio_to_n()   - decimation ratio code -> frame length N = 2^(ratio+1)
//   counter widths - sample counter (4 bits) and ADC timeout counter (8 bits)
package conv_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLEAR    = 3'd1,
    ST_START    = 3'd2,
    ST_WAIT_ADC = 3'd3,
    ST_ACCUM    = 3'd4,
    ST_FIR      = 3'd5,
    ST_ERR      = 3'd6
  } conv_state_t;

  localparam int SAMPLE_CNT_W  = 4;
  localparam int TIMEOUT_CNT_W = 8;

  // 0->2, 1->4, 2->8, 3->16; 16 needs the fifth bit.
  function automatic logic [4:0] ratio_to_n(input logic [1:0] ratio);
    return 5'd2 << ratio;
  endfunction

endpackage

// File: rtl/conv_sequencer_if.sv
// conv_sequencer_if: control and datapath strobes around the conversion sequencer.
//   conv_en, decimation_ratio   - from the register block
//   adc_ready / adc_convert     - ADC handshake: adc_convert is held while a
//                                 conversion is requested; adc_ready is a level
//                                 that is only looked at while the sequencer
//                                 waits for the ADC, so a stale or early ready
//                                 elsewhere has no effect.
//   cic_clr, cic_en, fir_en     - one-cycle datapath strobes
//   busy, timeout_err           - status back to the register block
// Modports: master = environment (register block / ADC / datapath side),
//           slave  = the sequencer.
interface conv_sequencer_if;
  logic       conv_en;
  logic [1:0] decimation_ratio;
  logic       adc_ready;
  logic       adc_convert;
  logic       cic_clr;
  logic       cic_en;
  logic       fir_en;
  logic       busy;
  logic       timeout_err;

  modport master (
    output conv_en, decimation_ratio, adc_ready,
    input  adc_convert, cic_clr, cic_en, fir_en, busy, timeout_err
  );

  modport slave (
    input  conv_en, decimation_ratio, adc_ready,
    output adc_convert, cic_clr, cic_en, fir_en, busy, timeout_err
  );
endinterface

// File: rtl/conv_sequencer.sv
// conv_sequencer: drives the ADC convert/ready handshake, clears the CIC at
// frame start, strobes the CIC once per accepted sample and the FIR once per
// completed frame of N samples. An ADC that does not answer within
// ADC_TIMEOUT cycles parks the FSM in ERR with a sticky timeout_err.
// Ports:
//   clk    - system clock, rising edge
//   rst    - synchronous reset, active-high
//   bus    - conv_sequencer_if.slave (register block, ADC and datapath signals)
//   state  - current FSM state, for observation
// All outputs are Moore decodes of the registered state.
module conv_sequencer
  import conv_seq_pkg::*;
#(
  parameter int ADC_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  conv_sequencer_if.slave     bus,
  output conv_state_t         state
);

  localparam logic [TIMEOUT_CNT_W-1:0] TIMEOUT_LAST = TIMEOUT_CNT_W'(ADC_TIMEOUT - 1);

  conv_state_t               state_q, state_d;
  logic [4:0]                n_q;
  logic [SAMPLE_CNT_W-1:0]   sample_cnt;
  logic [TIMEOUT_CNT_W-1:0]  timeout_cnt;
  logic                      err_q;

  logic latch_frame;
  logic clr_timeout;
  logic inc_timeout;
  logic inc_sample;
  logic set_err;
  logic clr_err;
  logic last_sample;

  assign last_sample = ({1'b0, sample_cnt} == (n_q - 5'd1));

  // Next-state and counter control.
  always_comb begin
    state_d     = state_q;
    latch_frame = 1'b0;
    clr_timeout = 1'b0;
    inc_timeout = 1'b0;
    inc_sample  = 1'b0;
    set_err     = 1'b0;
    clr_err     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.conv_en) begin
          state_d = ST_CLEAR;
          clr_err = 1'b1;
        end
      end
      ST_CLEAR: begin
        latch_frame = 1'b1;
        state_d     = ST_START;
      end
      ST_START: begin
        clr_timeout = 1'b1;
        state_d     = bus.conv_en ? ST_WAIT_ADC : ST_IDLE;
      end
      ST_WAIT_ADC: begin
        // Abort beats ready, ready beats timeout.
        if (!bus.conv_en) begin
          state_d = ST_IDLE;
        end else if (bus.adc_ready) begin
          state_d = ST_ACCUM;
        end else if (timeout_cnt == TIMEOUT_LAST) begin
          state_d = ST_ERR;
          set_err = 1'b1;
        end else begin
          inc_timeout = 1'b1;
        end
      end
      ST_ACCUM: begin
        inc_sample = 1'b1;
        state_d    = last_sample ? ST_FIR : ST_START;
      end
      ST_FIR: begin
        state_d = bus.conv_en ? ST_CLEAR : ST_IDLE;
      end
      ST_ERR: begin
        if (!bus.conv_en) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      n_q         <= 5'd2;
      sample_cnt  <= '0;
      timeout_cnt <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;

      // Frame length is frozen here so register writes mid-frame are ignored.
      if (latch_frame) begin
        n_q        <= ratio_to_n(bus.decimation_ratio);
        sample_cnt <= '0;
      end else if (inc_sample && (sample_cnt != '1)) begin
        sample_cnt <= sample_cnt + 1'b1;
      end

      if (clr_timeout) begin
        timeout_cnt <= '0;
      end else if (inc_timeout && (timeout_cnt != '1)) begin
        timeout_cnt <= timeout_cnt + 1'b1;
      end

      if (set_err) begin
        err_q <= 1'b1;
      end else if (clr_err) begin
        err_q <= 1'b0;
      end
    end
  end

  assign state           = state_q;
  assign bus.cic_clr     = (state_q == ST_CLEAR);
  assign bus.adc_convert = (state_q == ST_START) || (state_q == ST_WAIT_ADC);
  assign bus.cic_en      = (state_q == ST_ACCUM);
  assign bus.fir_en      = (state_q == ST_FIR);
  assign bus.busy        = (state_q != ST_IDLE) && (state_q != ST_ERR);
  assign bus.timeout_err = err_q;

endmodule

// File: tb/tb_conv_sequencer.sv
// tb_conv_sequencer: directed bench for conv_sequencer with ADC_TIMEOUT = 8.
// Output words are compared as {adc_convert, cic_clr, cic_en, fir_en, busy,
// timeout_err}. A table of per-cycle vectors covers reset, an N=2 frame with
// a mid-frame ratio change and a stray ready in IDLE; hand-written sequences
// cover frame lengths, abort, timeout, ready-at-expiry and reset mid-wait.
module tb_conv_sequencer;
  import conv_seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_sequencer_if bus();
  conv_state_t      state;

  conv_sequencer #(.ADC_TIMEOUT(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .state (state)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       rst;
    logic       conv_en;
    logic [1:0] ratio;
    logic       rdy;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[11];

  // ---------------- driver ----------------
  // Inputs change 1 time unit after the rising edge; outputs are then read
  // 1 time unit after the next rising edge.
  task automatic apply(input logic r, input logic ce, input logic [1:0] ra, input logic rd);
    rst                  = r;
    bus.conv_en          = ce;
    bus.decimation_ratio = ra;
    bus.adc_ready        = rd;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] outs();
    return {bus.adc_convert, bus.cic_clr, bus.cic_en, bus.fir_en, bus.busy, bus.timeout_err};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [5:0] exp);
    logic [5:0] got;
    got = outs();
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int en_cnt;
    int fir_cnt;
    int clr_cnt;
    int overlap;
    bit done;
    logic [5:0] o;

    bus.conv_en          = 1'b0;
    bus.decimation_ratio = 2'd0;
    bus.adc_ready        = 1'b0;
    @(posedge clk);
    #1;

    // rst ce ratio rdy   expected {conv,clr,en,fir,busy,err}
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 1'b0, 6'b000000}; // reset -> IDLE
    vecs[1]  = '{1'b0, 1'b0, 2'd0, 1'b1, 6'b000000}; // ready in IDLE ignored
    vecs[2]  = '{1'b0, 1'b1, 2'd0, 1'b0, 6'b010010}; // CLEAR
    vecs[3]  = '{1'b0, 1'b1, 2'd0, 1'b0, 6'b100010}; // START, N=2 latched
    vecs[4]  = '{1'b0, 1'b1, 2'd3, 1'b0, 6'b100010}; // WAIT, ratio change ignored
    vecs[5]  = '{1'b0, 1'b1, 2'd3, 1'b1, 6'b001010}; // ACCUM sample 0
    vecs[6]  = '{1'b0, 1'b1, 2'd3, 1'b0, 6'b100010}; // START
    vecs[7]  = '{1'b0, 1'b1, 2'd3, 1'b0, 6'b100010}; // WAIT
    vecs[8]  = '{1'b0, 1'b1, 2'd3, 1'b1, 6'b001010}; // ACCUM sample 1
    vecs[9]  = '{1'b0, 1'b1, 2'd3, 1'b0, 6'b000110}; // FIR
    vecs[10] = '{1'b0, 1'b1, 2'd3, 1'b0, 6'b010010}; // CLEAR of next frame

    for (int i = 0; i < 11; i++) begin
      apply(vecs[i].rst, vecs[i].conv_en, vecs[i].ratio, vecs[i].rdy);
      check($sformatf("vec%0d", i), vecs[i].exp);
      if (i == 0) check_val("reset_state", int'(state), int'(ST_IDLE));
    end

    // N=16 frame (ratio 3 latched leaving CLEAR), ready held high so each
    // sample takes START/WAIT/ACCUM. Ratio is moved to 1 mid-frame.
    cyc = 0; en_cnt = 0; clr_cnt = 0; overlap = 0; done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      apply(1'b0, 1'b1, (i == 0) ? 2'd3 : 2'd1, 1'b1);
      cyc++;
      o = outs();
      if (o[3]) en_cnt++;
      if (o[4]) clr_cnt++;
      if ($countones(o[4:2]) > 1) overlap++;
      if (o[2]) done = 1'b1;
    end
    check_val("n16_fir_seen", int'(done), 1);
    check_val("n16_clear_to_fir", cyc, 49);
    check_val("n16_cic_en_count", en_cnt, 16);
    check_val("n16_extra_clr", clr_cnt, 0);
    check_val("n16_strobe_overlap", overlap, 0);

    // Ratio 1: frame period from one cic_clr to the next is 1 + 3*4 + 1.
    apply(1'b0, 1'b1, 2'd1, 1'b1);
    check("n4_clear", 6'b010010);
    cyc = 0; en_cnt = 0; fir_cnt = 0; overlap = 0; done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      apply(1'b0, 1'b1, 2'd1, 1'b1);
      cyc++;
      o = outs();
      if (o[3]) en_cnt++;
      if (o[2]) fir_cnt++;
      if ($countones(o[4:2]) > 1) overlap++;
      if (o[4]) done = 1'b1;
    end
    check_val("n4_period", cyc, 14);
    check_val("n4_cic_en_count", en_cnt, 4);
    check_val("n4_fir_count", fir_cnt, 1);
    check_val("n4_strobe_overlap", overlap, 0);

    // Abort in WAIT with sample 2 of 4 pending (now in CLEAR, N=4).
    apply(1'b0, 1'b1, 2'd1, 1'b1);  // START
    apply(1'b0, 1'b1, 2'd1, 1'b1);  // WAIT
    apply(1'b0, 1'b1, 2'd1, 1'b1);  // ACCUM sample 0
    check("abort_accum0", 6'b001010);
    apply(1'b0, 1'b1, 2'd1, 1'b0);  // START
    apply(1'b0, 1'b1, 2'd1, 1'b0);  // WAIT
    check("abort_wait", 6'b100010);
    apply(1'b0, 1'b0, 2'd1, 1'b0);
    check("abort_idle", 6'b000000);
    fir_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b0, 2'd1, 1'b0);
      if (outs() != 6'b000000) fir_cnt++;
    end
    check_val("abort_stays_quiet", fir_cnt, 0);

    // Timeout: 8 cycles in WAIT without ready -> ERR.
    apply(1'b0, 1'b1, 2'd0, 1'b0);  // CLEAR
    apply(1'b0, 1'b1, 2'd0, 1'b0);  // START
    apply(1'b0, 1'b1, 2'd0, 1'b0);  // WAIT entry
    check("to_wait_entry", 6'b100010);
    for (int i = 0; i < 7; i++) apply(1'b0, 1'b1, 2'd0, 1'b0);
    check("to_wait_last", 6'b100010);
    apply(1'b0, 1'b1, 2'd0, 1'b0);
    check("to_err", 6'b000001);
    check_val("to_err_state", int'(state), int'(ST_ERR));
    apply(1'b0, 1'b1, 2'd0, 1'b1);
    check("to_err_hold", 6'b000001);
    apply(1'b0, 1'b0, 2'd0, 1'b0);
    check("to_idle_sticky", 6'b000001);
    apply(1'b0, 1'b1, 2'd0, 1'b0);
    check("to_restart_clears", 6'b010010);

    // Ready in the same cycle the timeout would expire: ready wins.
    apply(1'b0, 1'b1, 2'd0, 1'b0);  // START
    apply(1'b0, 1'b1, 2'd0, 1'b0);  // WAIT entry
    for (int i = 0; i < 7; i++) apply(1'b0, 1'b1, 2'd0, 1'b0);
    apply(1'b0, 1'b1, 2'd0, 1'b1);
    check("race_accum", 6'b001010);
    apply(1'b0, 1'b1, 2'd0, 1'b0);
    check("race_next_start", 6'b100010);
    apply(1'b0, 1'b0, 2'd0, 1'b0);
    check("race_abort_start", 6'b000000);

    // Reset mid-WAIT.
    apply(1'b0, 1'b1, 2'd0, 1'b0);  // CLEAR
    apply(1'b0, 1'b1, 2'd0, 1'b0);  // START
    apply(1'b0, 1'b1, 2'd0, 1'b0);  // WAIT
    check("rst_pre_wait", 6'b100010);
    apply(1'b1, 1'b1, 2'd0, 1'b0);
    check("rst_mid_wait", 6'b000000);
    check_val("rst_mid_wait_state", int'(state), int'(ST_IDLE));
    apply(1'b0, 1'b1, 2'd0, 1'b0);
    check("rst_restart_clear", 6'b010010);
    apply(1'b0, 1'b0, 2'd0, 1'b0);  // START
    apply(1'b0, 1'b0, 2'd0, 1'b0);
    check("rst_final_idle", 6'b000000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog: the directed sequence is a few hundred cycles.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
